csr_access_unit: RTL and testbench

Execute-side sequencer for Zicsr instructions (CSRRW/RS/RC and immediate forms). It accepts one decoded CSR operation at a time and performs the read-modify-write against the CSR register file, whose read data is registered (one cycle). It returns the old CSR value for rd writeback to the pipeline and flags illegal accesses.

---
 rtl/csr_access_unit.sv | 144 ++++++++++++++
 tb/tb_csr_access_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// Zicsr execute sequencer: read-modify-write against a CSR file with
// registered read data, returning the old CSR value for rd writeback.
module csr_access_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [4:0]      rs1_idx_i,
    input  logic [4:0]      rd_idx_i,
    input  logic            flush_i,
    output logic [11:0]     csr_address_o,
    output logic            csr_read_enable_o,
    output logic            csr_write_enable_o,
    output logic [XLEN-1:0] csr_write_data_o,
    input  logic [XLEN-1:0] csr_read_data_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [4:0]      rd_idx_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_we_o,
    output logic            illegal_o
);

    // state | meaning
    // IDLE  | waiting for a decoded CSR op
    // READ  | read enable pulse toward the CSR file
    // WRITE | read data returns, new value written, old value captured
    // RESP  | result presented until result_ready_i
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]      state;
    logic [1:0]      op_q;
    logic [11:0]     addr_q;
    logic [4:0]      rd_idx_q;
    logic [XLEN-1:0] operand_q;
    logic            read_needed_q;
    logic            write_needed_q;
    logic            illegal_q;
    logic [XLEN-1:0] rd_data_q;

    logic            accept;
    logic            is_rw;
    logic            read_needed;
    logic            write_needed;
    logic            addr_ok;
    logic            illegal;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] old_value;
    logic [XLEN-1:0] new_value;

    assign ready_o = (state == IDLE);
    // A flush in the accept cycle cancels the offered op.
    assign accept  = valid_i && ready_o && !flush_i;

    always_comb begin
        addr_ok = 1'b0;
        case (csr_addr_i)
            12'h300, 12'h301, 12'h304, 12'h305,
            12'h340, 12'h341, 12'h342, 12'h344: addr_ok = 1'b1;
            default:                            addr_ok = 1'b0;
        endcase
    end

    assign is_rw        = (funct3_i[1:0] == 2'b01);
    assign read_needed  = !(is_rw && (rd_idx_i == 5'd0));
    assign write_needed = is_rw || (rs1_idx_i != 5'd0);
    assign illegal      = (funct3_i[1:0] == 2'b00) || !addr_ok ||
                          ((csr_addr_i[11:10] == 2'b11) && write_needed);
    assign operand      = funct3_i[2] ? {{(XLEN-5){1'b0}}, rs1_idx_i} : rs1_data_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= IDLE;
            op_q           <= 2'b00;
            addr_q         <= 12'h000;
            rd_idx_q       <= 5'd0;
            operand_q      <= '0;
            read_needed_q  <= 1'b0;
            write_needed_q <= 1'b0;
            illegal_q      <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q           <= funct3_i[1:0];
                        addr_q         <= csr_addr_i;
                        rd_idx_q       <= rd_idx_i;
                        operand_q      <= operand;
                        read_needed_q  <= read_needed;
                        write_needed_q <= write_needed;
                        illegal_q      <= illegal;
                        rd_data_q      <= '0;
                        state          <= illegal ? RESP : READ;
                    end
                end
                READ: begin
                    state <= flush_i ? IDLE : WRITE;
                end
                WRITE: begin
                    rd_data_q <= old_value;
                    state     <= RESP;
                end
                default: begin
                    if (result_ready_i) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign old_value = read_needed_q ? csr_read_data_i : '0;

    always_comb begin
        new_value = operand_q;
        case (op_q)
            2'b10:   new_value = old_value | operand_q;
            2'b11:   new_value = old_value & ~operand_q;
            default: new_value = operand_q;
        endcase
    end

    // All outputs decode from the state register so reset clears them at once.
    assign csr_address_o      = (state == IDLE) ? 12'h000 : addr_q;
    assign csr_read_enable_o  = (state == READ) && read_needed_q;
    assign csr_write_enable_o = (state == WRITE) && write_needed_q;
    assign csr_write_data_o   = (state == WRITE) ? new_value : '0;

    assign result_valid_o = (state == RESP);
    assign illegal_o      = (state == RESP) && illegal_q;
    assign rd_we_o        = (state == RESP) && !illegal_q && (rd_idx_q != 5'd0);
    assign rd_idx_o       = (state == RESP) ? rd_idx_q : 5'd0;
    assign rd_data_o      = (state == RESP) ? rd_data_q : '0;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a small registered-read CSR file model.
module tb_csr_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  funct3_i = 3'b000;
    logic [11:0] csr_addr_i = 12'h000;
    logic [31:0] rs1_data_i = 32'h0;
    logic [4:0]  rs1_idx_i = 5'd0;
    logic [4:0]  rd_idx_i = 5'd0;
    logic        flush_i = 1'b0;
    logic [11:0] csr_address_o;
    logic        csr_read_enable_o;
    logic        csr_write_enable_o;
    logic [31:0] csr_write_data_o;
    logic [31:0] csr_read_data_i = 32'h0;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [4:0]  rd_idx_o;
    logic [31:0] rd_data_o;
    logic        rd_we_o;
    logic        illegal_o;

    int checks = 0;
    int fails  = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    int rv_cycles = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] csr_mem [0:4095];

    csr_access_unit #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .funct3_i(funct3_i), .csr_addr_i(csr_addr_i), .rs1_data_i(rs1_data_i),
        .rs1_idx_i(rs1_idx_i), .rd_idx_i(rd_idx_i), .flush_i(flush_i),
        .csr_address_o(csr_address_o), .csr_read_enable_o(csr_read_enable_o),
        .csr_write_enable_o(csr_write_enable_o), .csr_write_data_o(csr_write_data_o),
        .csr_read_data_i(csr_read_data_i), .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i), .rd_idx_o(rd_idx_o), .rd_data_o(rd_data_o),
        .rd_we_o(rd_we_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // CSR file: read data registered one cycle after the read enable.
    always @(posedge clk_i) begin
        if (csr_write_enable_o) csr_mem[csr_address_o] <= csr_write_data_o;
        if (csr_read_enable_o)  csr_read_data_i <= csr_mem[csr_address_o];
    end

    always @(negedge clk_i) begin
        if (csr_read_enable_o) rd_pulses++;
        if (csr_write_enable_o) begin
            wr_pulses++;
            last_wdata = csr_write_data_o;
        end
        if (result_valid_o) rv_cycles++;
    end

    task automatic clear_mon();
        rd_pulses = 0;
        wr_pulses = 0;
        rv_cycles = 0;
        last_wdata = 32'h0;
    endtask

    // Presents one op at a negedge; returns #1 after the accepting edge (cycle 1).
    task automatic issue(input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] rs1d, input logic [4:0] rs1i,
                         input logic [4:0] rd);
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = f3; csr_addr_i = addr;
        rs1_data_i = rs1d; rs1_idx_i = rs1i; rd_idx_i = rd;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    // Cycles after accept until result_valid_o; 99 if it never comes.
    task automatic wait_resp(output int n);
        n = 99;
        for (int i = 1; i <= 12; i++) begin
            if (result_valid_o) begin
                n = i;
                break;
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic finish_resp();
        result_ready_i = 1'b1;
        @(posedge clk_i); #1;
        result_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", ready_o); end
        checks++; if (result_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", result_valid_o); end
        checks++; if ({csr_read_enable_o, csr_write_enable_o} !== 2'b00) begin fails++; $display("FAIL reset_en got %b exp 00", {csr_read_enable_o, csr_write_enable_o}); end
        checks++; if (csr_address_o !== 12'h0 || rd_data_o !== 32'h0 || illegal_o !== 1'b0 || rd_we_o !== 1'b0) begin
            fails++; $display("FAIL reset_outs addr %h rd_data %h ill %b we %b exp zeros", csr_address_o, rd_data_o, illegal_o, rd_we_o);
        end
    endtask

    task automatic test_rw();
        clear_mon();
        csr_mem[12'h340] = 32'h11;
        issue(3'b001, 12'h340, 32'hDEADBEEF, 5'd3, 5'd5);
        checks++; if (csr_read_enable_o !== 1'b1 || csr_address_o !== 12'h340) begin
            fails++; $display("FAIL rw_read_cycle re %b addr %h exp 1 340", csr_read_enable_o, csr_address_o);
        end
        checks++; if (ready_o !== 1'b0) begin fails++; $display("FAIL rw_busy got %b exp 0", ready_o); end
        @(posedge clk_i); #1;
        checks++; if (csr_write_enable_o !== 1'b1 || csr_write_data_o !== 32'hDEADBEEF || csr_read_enable_o !== 1'b0) begin
            fails++; $display("FAIL rw_write_cycle we %b wd %h re %b exp 1 deadbeef 0", csr_write_enable_o, csr_write_data_o, csr_read_enable_o);
        end
        @(posedge clk_i); #1;
        checks++; if (result_valid_o !== 1'b1 || rd_data_o !== 32'h11 || rd_we_o !== 1'b1 || rd_idx_o !== 5'd5 || illegal_o !== 1'b0) begin
            fails++; $display("FAIL rw_resp v %b d %h we %b idx %0d ill %b exp 1 11 1 5 0", result_valid_o, rd_data_o, rd_we_o, rd_idx_o, illegal_o);
        end
        checks++; if (csr_address_o !== 12'h340 || csr_write_enable_o !== 1'b0) begin
            fails++; $display("FAIL rw_resp_addr addr %h we %b exp 340 0", csr_address_o, csr_write_enable_o);
        end
        // Ready in the first RESP cycle completes the op immediately.
        finish_resp();
        checks++; if (ready_o !== 1'b1 || result_valid_o !== 1'b0 || csr_address_o !== 12'h0) begin
            fails++; $display("FAIL rw_done ready %b valid %b addr %h exp 1 0 000", ready_o, result_valid_o, csr_address_o);
        end
        checks++; if (csr_mem[12'h340] !== 32'hDEADBEEF || rd_pulses != 1 || wr_pulses != 1) begin
            fails++; $display("FAIL rw_effect mem %h rdp %0d wrp %0d exp deadbeef 1 1", csr_mem[12'h340], rd_pulses, wr_pulses);
        end
    endtask

    task automatic test_x0_forms();
        int n;
        clear_mon();
        csr_mem[12'h300] = 32'h1888;
        issue(3'b010, 12'h300, 32'hFFFF_FFFF, 5'd0, 5'd0);
        wait_resp(n);
        checks++; if (n != 3) begin fails++; $display("FAIL rs_x0_latency got %0d exp 3", n); end
        checks++; if (rd_pulses != 1 || wr_pulses != 0 || rd_we_o !== 1'b0 || rd_data_o !== 32'h1888) begin
            fails++; $display("FAIL rs_x0 rdp %0d wrp %0d we %b d %h exp 1 0 0 1888", rd_pulses, wr_pulses, rd_we_o, rd_data_o);
        end
        finish_resp();
        checks++; if (csr_mem[12'h300] !== 32'h1888) begin fails++; $display("FAIL rs_x0_mem got %h exp 1888", csr_mem[12'h300]); end
        clear_mon();
        issue(3'b001, 12'h340, 32'h0000_0055, 5'd9, 5'd0);
        wait_resp(n);
        checks++; if (n != 3 || rd_pulses != 0 || wr_pulses != 1 || rd_data_o !== 32'h0 || rd_we_o !== 1'b0) begin
            fails++; $display("FAIL rw_x0 lat %0d rdp %0d wrp %0d d %h we %b exp 3 0 1 0 0", n, rd_pulses, wr_pulses, rd_data_o, rd_we_o);
        end
        finish_resp();
        checks++; if (csr_mem[12'h340] !== 32'h55) begin fails++; $display("FAIL rw_x0_mem got %h exp 55", csr_mem[12'h340]); end
    endtask

    task automatic test_rci();
        int n;
        clear_mon();
        csr_mem[12'h304] = 32'hF;
        issue(3'b111, 12'h304, 32'hFFFF_FFFF, 5'd5, 5'd7);
        wait_resp(n);
        checks++; if (n != 3 || last_wdata !== 32'hA || wr_pulses != 1) begin
            fails++; $display("FAIL rci_write lat %0d wd %h wrp %0d exp 3 a 1", n, last_wdata, wr_pulses);
        end
        checks++; if (rd_data_o !== 32'hF || rd_idx_o !== 5'd7 || rd_we_o !== 1'b1) begin
            fails++; $display("FAIL rci_resp d %h idx %0d we %b exp f 7 1", rd_data_o, rd_idx_o, rd_we_o);
        end
        finish_resp();
        checks++; if (csr_mem[12'h304] !== 32'hA) begin fails++; $display("FAIL rci_mem got %h exp a", csr_mem[12'h304]); end
    endtask

    task automatic test_rsi_or();
        int n;
        clear_mon();
        csr_mem[12'h305] = 32'h100;
        issue(3'b110, 12'h305, 32'h0, 5'd3, 5'd1);
        wait_resp(n);
        checks++; if (n != 3 || last_wdata !== 32'h103 || rd_data_o !== 32'h100) begin
            fails++; $display("FAIL rsi lat %0d wd %h d %h exp 3 103 100", n, last_wdata, rd_data_o);
        end
        finish_resp();
    endtask

    task automatic test_illegal();
        logic [2:0]  f3s [3]  = '{3'b001, 3'b100, 3'b001};
        logic [11:0] adrs [3] = '{12'h7C0, 12'h340, 12'hC00};
        int n;
        for (int k = 0; k < 3; k++) begin
            clear_mon();
            issue(f3s[k], adrs[k], 32'h1234, 5'd2, 5'd4);
            wait_resp(n);
            checks++; if (n != 1 || illegal_o !== 1'b1 || rd_we_o !== 1'b0 || rd_data_o !== 32'h0) begin
                fails++; $display("FAIL illegal_%0d lat %0d ill %b we %b d %h exp 1 1 0 0", k, n, illegal_o, rd_we_o, rd_data_o);
            end
            finish_resp();
            checks++; if (rd_pulses != 0 || wr_pulses != 0 || ready_o !== 1'b1) begin
                fails++; $display("FAIL illegal_en_%0d rdp %0d wrp %0d ready %b exp 0 0 1", k, rd_pulses, wr_pulses, ready_o);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        csr_mem[12'h341] = 32'h8000_0010;
        issue(3'b010, 12'h341, 32'h1, 5'd6, 5'd12);
        wait_resp(n);
        checks++; if (n != 3) begin fails++; $display("FAIL bp_latency got %0d exp 3", n); end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (result_valid_o !== 1'b1 || ready_o !== 1'b0 || rd_data_o !== 32'h8000_0010 ||
                rd_idx_o !== 5'd12 || rd_we_o !== 1'b1 || csr_address_o !== 12'h341 || csr_write_enable_o !== 1'b0) begin
                fails++; $display("FAIL bp_hold_%0d v %b rdy %b d %h idx %0d we %b addr %h exp 1 0 80000010 12 1 341", c, result_valid_o, ready_o, rd_data_o, rd_idx_o, rd_we_o, csr_address_o);
            end
            if (c < 4) begin @(posedge clk_i); #1; end
        end
        @(posedge clk_i); #1;
        finish_resp();
        checks++; if (ready_o !== 1'b1 || result_valid_o !== 1'b0) begin
            fails++; $display("FAIL bp_release ready %b valid %b exp 1 0", ready_o, result_valid_o);
        end
        checks++; if (csr_mem[12'h341] !== 32'h8000_0011) begin fails++; $display("FAIL bp_mem got %h exp 80000011", csr_mem[12'h341]); end
    endtask

    task automatic test_flush();
        clear_mon();
        csr_mem[12'h342] = 32'h77;
        issue(3'b001, 12'h342, 32'h99, 5'd1, 5'd2);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        checks++; if (ready_o !== 1'b1 || csr_write_enable_o !== 1'b0) begin
            fails++; $display("FAIL flush_read ready %b we %b exp 1 0", ready_o, csr_write_enable_o);
        end
        repeat (4) @(posedge clk_i);
        #1;
        checks++; if (wr_pulses != 0 || rv_cycles != 0 || csr_mem[12'h342] !== 32'h77) begin
            fails++; $display("FAIL flush_effect wrp %0d rv %0d mem %h exp 0 0 77", wr_pulses, rv_cycles, csr_mem[12'h342]);
        end
        clear_mon();
        @(negedge clk_i);
        valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b001; csr_addr_i = 12'h342; rd_idx_i = 5'd2;
        @(posedge clk_i); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        checks++; if (ready_o !== 1'b1 || csr_read_enable_o !== 1'b0) begin
            fails++; $display("FAIL flush_idle ready %b re %b exp 1 0", ready_o, csr_read_enable_o);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        csr_mem[12'h344] = 32'h5A5A;
        issue(3'b001, 12'h344, 32'hCAFE, 5'd1, 5'd3);
        @(posedge clk_i); #1;
        checks++; if (csr_write_enable_o !== 1'b1) begin fails++; $display("FAIL rstmid_pre we %b exp 1", csr_write_enable_o); end
        rst_i = 1'b0;
        #1;
        checks++; if (csr_write_enable_o !== 1'b0 || csr_address_o !== 12'h0 || ready_o !== 1'b1 ||
                      csr_write_data_o !== 32'h0 || result_valid_o !== 1'b0) begin
            fails++; $display("FAIL rstmid we %b addr %h rdy %b wd %h v %b exp 0 000 1 0 0", csr_write_enable_o, csr_address_o, ready_o, csr_write_data_o, result_valid_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (csr_mem[12'h344] !== 32'h5A5A || rv_cycles != 0 || ready_o !== 1'b1) begin
            fails++; $display("FAIL rstmid_after mem %h rv %0d rdy %b exp 5a5a 0 1", csr_mem[12'h344], rv_cycles, ready_o);
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) csr_mem[a] = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        test_rw();
        test_x0_forms();
        test_rci();
        test_rsi_or();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
